fetch_unit: RTL and testbench

Instruction fetch stage of the 5-stage RV32I pipeline. It owns the PC, issues word reads to instruction memory over a valid/ready request and valid response interface, and presents pc/next_pc/instruction/valid to decode. It obeys hazard stall/invalidate and accepts PC redirects from execute/trap logic. At most one read is outstanding, and a one-entry buffer absorbs a response that arrives while decode is stalled.

---
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, and presents pc/next_pc/instruction/valid to decode.
// A one-entry buffer holds a response that arrives while decode is stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory request
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_address,
  // instruction memory response
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_error,
  // hazard and redirect control
  input  logic        stall,
  input  logic        invalidate,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // to decode
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_redir_q, pend_redir_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic        halted_q, halted_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_data_q;
  logic        buf_err_q;

  logic        accept, req_wait, redir_apply, rsp_ok;
  logic        buf_load, rsp_load, load, misaligned, buf_fill;
  logic [31:0] redir_target;
  logic [31:0] ld_pc, ld_data;
  logic        ld_err;

  // Request handshake and redirect/response qualification
  always_comb begin
    // Depends on registers only; rst_n gating keeps the request quiet during reset.
    mem_req_valid   = rst_n & ~outstanding_q & ~buf_valid_q & ~halted_q & (pc_q[1:0] == 2'b00);
    mem_req_address = pc_q;
    accept          = mem_req_valid & mem_req_ready;
    req_wait        = mem_req_valid & ~mem_req_ready;
    // A redirect must not disturb a request that is still waiting for ready.
    redir_apply     = (redirect_valid | pend_redir_q) & ~req_wait;
    redir_target    = redirect_valid ? redirect_pc : pend_pc_q;
    rsp_ok          = mem_rsp_valid & ~discard_q & ~invalidate & ~redir_apply;
    buf_load        = ~stall & ~invalidate & ~redir_apply & buf_valid_q;
    rsp_load        = ~stall & ~invalidate & rsp_ok & ~buf_valid_q;
    buf_fill        = stall & ~invalidate & rsp_ok;
    load            = buf_load | rsp_load;
    misaligned      = ~stall & ~invalidate & ~redir_apply & ~outstanding_q & ~buf_valid_q &
                      ~halted_q & (pc_q[1:0] != 2'b00);
    ld_pc           = buf_load ? buf_pc_q   : req_pc_q;
    ld_data         = buf_load ? buf_data_q : mem_rsp_data;
    ld_err          = buf_load ? buf_err_q  : mem_rsp_error;
  end

  // Next-state for PC, outstanding/discard tracking, buffer and halt
  always_comb begin
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    pend_pc_d     = pend_pc_q;
    pend_redir_d  = pend_redir_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    halted_d      = halted_q;
    buf_valid_d   = buf_valid_q;

    if (accept) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
    if (redir_apply) begin
      pc_d = redir_target;
    end

    if (redirect_valid && req_wait) begin
      pend_redir_d = 1'b1;
      pend_pc_d    = redirect_pc;
    end else if (redir_apply) begin
      pend_redir_d = 1'b0;
    end

    if (mem_rsp_valid) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (accept) begin
      outstanding_d = 1'b1;
    end
    // A response landing in the redirect cycle is already dropped; only later ones need discard.
    if (redir_apply && ((outstanding_q && !mem_rsp_valid) || accept)) begin
      discard_d = 1'b1;
    end

    if (invalidate || redir_apply) begin
      buf_valid_d = 1'b0;
    end else if (buf_fill) begin
      buf_valid_d = 1'b1;
    end else if (buf_load) begin
      buf_valid_d = 1'b0;
    end

    if ((load && ld_err) || misaligned) begin
      halted_d = 1'b1;
    end
    if (redir_apply) begin
      halted_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_VECTOR;
      req_pc_q      <= 32'h0;
      pend_pc_q     <= 32'h0;
      pend_redir_q  <= 1'b0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      halted_q      <= 1'b0;
      buf_valid_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_redir_q  <= pend_redir_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
      buf_valid_q   <= buf_valid_d;
    end
  end

  // Capture a response that arrives while decode is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_pc_q   <= 32'h0;
      buf_data_q <= 32'h0;
      buf_err_q  <= 1'b0;
    end else if (buf_fill) begin
      buf_pc_q   <= req_pc_q;
      buf_data_q <= mem_rsp_data;
      buf_err_q  <= mem_rsp_error;
    end
  end

  // Registered decode-facing outputs; invalidate beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out          <= 32'h0;
      next_pc_out     <= 32'h0;
      instruction_out <= 32'h0;
      valid_out       <= 1'b0;
      exception_out   <= 1'b0;
      ecause_out      <= 4'd0;
    end else if (invalidate) begin
      valid_out <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        valid_out       <= 1'b1;
        pc_out          <= ld_pc;
        next_pc_out     <= ld_pc + 32'd4;
        instruction_out <= ld_err ? 32'h0 : ld_data;
        exception_out   <= ld_err;
        ecause_out      <= ld_err ? 4'd1 : 4'd0;
      end else if (misaligned) begin
        valid_out       <= 1'b1;
        pc_out          <= pc_q;
        next_pc_out     <= pc_q + 32'd4;
        instruction_out <= 32'h0;
        exception_out   <= 1'b1;
        ecause_out      <= 4'd0;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction-memory responder.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_address;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_error;
  logic        stall, invalidate, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, next_pc_out, instruction_out;
  logic        valid_out, exception_out;
  logic [3:0]  ecause_out;

  int checks = 0;
  int failures = 0;

  // responder state
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] req_log[$];

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_address(mem_req_address),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_error  (mem_rsp_error),
    .stall          (stall),
    .invalidate     (invalidate),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_out         (pc_out),
    .next_pc_out    (next_pc_out),
    .instruction_out(instruction_out),
    .valid_out      (valid_out),
    .exception_out  (exception_out),
    .ecause_out     (ecause_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Memory responder: acts on the falling edge, response 'lat' cycles after acceptance
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_rsp_error = 1'b0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_error = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word_of(pend_addr);
            mem_rsp_error = (pend_addr == err_addr);
            pend = 0;
          end else begin
            cnt--;
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          pend      = 1;
          cnt       = lat - 1;
          pend_addr = mem_req_address;
          req_log.push_back(mem_req_address);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid_out === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    checks++; if (next_pc_out !== 32'h0) begin failures++; $display("FAIL reset_npc got=%h exp=0", next_pc_out); end
    checks++; if (instruction_out !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction_out); end
    checks++; if ({exception_out, ecause_out} !== 5'h0) begin failures++; $display("FAIL reset_exc got=%b/%h exp=0/0", exception_out, ecause_out); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req_valid); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL release_req got=%b exp=1", mem_req_valid); end
    checks++; if (mem_req_address !== RV) begin failures++; $display("FAIL release_addr got=%h exp=%h", mem_req_address, RV); end
  endtask

  task automatic test_stream();
    bit ok;
    wait_valid(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stream_to0 got=none exp=valid"); end
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL stream_pc0 got=%h exp=100", pc_out); end
    checks++; if (next_pc_out !== 32'h104) begin failures++; $display("FAIL stream_npc0 got=%h exp=104", next_pc_out); end
    checks++; if (instruction_out !== word_of(32'h100)) begin failures++; $display("FAIL stream_ins0 got=%h exp=%h", instruction_out, word_of(32'h100)); end
    checks++; if (exception_out !== 1'b0) begin failures++; $display("FAIL stream_exc0 got=%b exp=0", exception_out); end
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL stream_gap got=%b exp=0", valid_out); end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h104 || next_pc_out !== 32'h108) begin failures++; $display("FAIL stream_pc1 got=%h/%h exp=104/108", pc_out, next_pc_out); end
    checks++; if (instruction_out !== word_of(32'h104)) begin failures++; $display("FAIL stream_ins1 got=%h exp=%h", instruction_out, word_of(32'h104)); end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h108 || next_pc_out !== 32'h10C) begin failures++; $display("FAIL stream_pc2 got=%h/%h exp=108/10c", pc_out, next_pc_out); end
    checks++; if (instruction_out !== word_of(32'h108)) begin failures++; $display("FAIL stream_ins2 got=%h exp=%h", instruction_out, word_of(32'h108)); end
    checks++; if (req_log.size() != 3) begin failures++; $display("FAIL stream_nreq got=%0d exp=3", req_log.size()); end
    else begin
      checks++; if (req_log[0] !== 32'h100 || req_log[1] !== 32'h104 || req_log[2] !== 32'h108) begin
        failures++; $display("FAIL stream_reqs got=%h,%h,%h exp=100,104,108", req_log[0], req_log[1], req_log[2]);
      end
    end
  endtask

  task automatic test_stall_buffer();
    bit ok;
    do_reset();
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h100) begin failures++; $display("FAIL stall_first got=%h exp=100", pc_out); end
    stall = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h100) begin failures++; $display("FAIL stall_hold0 got=%b/%h exp=1/100", valid_out, pc_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_out !== 32'h100 || valid_out !== 1'b1) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/100", valid_out, pc_out); end
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_noreq got=%b exp=0", mem_req_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h104) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/104", valid_out, pc_out); end
    checks++; if (instruction_out !== word_of(32'h104)) begin failures++; $display("FAIL stall_ins got=%h exp=%h", instruction_out, word_of(32'h104)); end
    lat = 2;
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL stall_nodup got=%b exp=0", valid_out); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_outst got=%b exp=0", mem_req_valid); end
  endtask

  // Continues from the stall test with the 0x108 read outstanding
  task automatic test_redirect_discard();
    bit ok;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    lat = 1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL redir_v0 got=%b exp=0", valid_out); end
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL redir_drop got=%b/%h exp=0", valid_out, pc_out); end
    checks++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'h200) begin failures++; $display("FAIL redir_req got=%b/%h exp=1/200", mem_req_valid, mem_req_address); end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h200) begin failures++; $display("FAIL redir_pc got=%h exp=200", pc_out); end
    checks++; if (instruction_out !== word_of(32'h200)) begin failures++; $display("FAIL redir_ins got=%h exp=%h", instruction_out, word_of(32'h200)); end
  endtask

  task automatic test_misaligned();
    bit ok;
    int n;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    tick();
    redirect_valid = 1'b0;
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h202) begin failures++; $display("FAIL mis_pc got=%h exp=202", pc_out); end
    checks++; if (exception_out !== 1'b1 || ecause_out !== 4'd0) begin failures++; $display("FAIL mis_exc got=%b/%h exp=1/0", exception_out, ecause_out); end
    checks++; if (instruction_out !== 32'h0) begin failures++; $display("FAIL mis_ins got=%h exp=0", instruction_out); end
    n = req_log.size();
    repeat (5) tick();
    checks++; if (mem_req_valid !== 1'b0 || req_log.size() != n) begin failures++; $display("FAIL mis_halt got=%b/%0d exp=0/%0d", mem_req_valid, req_log.size(), n); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mis_vdrop got=%b exp=0", valid_out); end
  endtask

  task automatic test_access_fault();
    bit ok;
    int n;
    err_addr       = 32'h300;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'h300) begin failures++; $display("FAIL fault_req got=%b/%h exp=1/300", mem_req_valid, mem_req_address); end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h300) begin failures++; $display("FAIL fault_pc got=%h exp=300", pc_out); end
    checks++; if (exception_out !== 1'b1 || ecause_out !== 4'd1) begin failures++; $display("FAIL fault_exc got=%b/%h exp=1/1", exception_out, ecause_out); end
    checks++; if (instruction_out !== 32'h0) begin failures++; $display("FAIL fault_ins got=%h exp=0", instruction_out); end
    n = req_log.size();
    repeat (6) tick();
    checks++; if (mem_req_valid !== 1'b0 || req_log.size() != n) begin failures++; $display("FAIL fault_halt got=%b/%0d exp=0/%0d", mem_req_valid, req_log.size(), n); end
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_invalidate();
    bit ok;
    do_reset();
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h100 || exception_out !== 1'b0) begin failures++; $display("FAIL inv_first got=%h/%b exp=100/0", pc_out, exception_out); end
    stall = 1'b1;
    tick();
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL inv_buffull got=%b exp=0", mem_req_valid); end
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    stall      = 1'b0;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL inv_valid got=%b exp=0", valid_out); end
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'h108) begin failures++; $display("FAIL inv_nextreq got=%b/%h exp=1/108", mem_req_valid, mem_req_address); end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h108) begin failures++; $display("FAIL inv_next got=%h exp=108", pc_out); end
  endtask

  task automatic test_reset_mid_request();
    bit ok;
    lat = 3;
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rmid_outst got=%b exp=0", mem_req_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (pc_out !== 32'h0 || next_pc_out !== 32'h0 || instruction_out !== 32'h0) begin
      failures++; $display("FAIL rmid_zero got=%h/%h/%h exp=0/0/0", pc_out, next_pc_out, instruction_out);
    end
    checks++; if (valid_out !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rmid_ctl got=%b/%b exp=0/0", valid_out, mem_req_valid); end
    tick();
    tick();
    lat   = 1;
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_address !== RV) begin failures++; $display("FAIL rmid_req got=%b/%h exp=1/%h", mem_req_valid, mem_req_address, RV); end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out !== 32'h100 || instruction_out !== word_of(32'h100)) begin
      failures++; $display("FAIL rmid_first got=%h/%h exp=100/%h", pc_out, instruction_out, word_of(32'h100));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    mem_req_ready  = 1'b1;
    stall          = 1'b0;
    invalidate     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_stream();
    test_stall_buffer();
    test_redirect_discard();
    test_misaligned();
    test_access_fault();
    test_invalidate();
    test_reset_mid_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
